// File: rtl/packer_pkg.sv
// Shared constants and FSM state type for the compressed stream packer.
package packer_pkg;

   localparam int HDR_BYTES       = 2;
   localparam int MAX_GROUP_BYTES = 34;
   localparam int BUF_BYTES       = 64;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LAST  = 2'd2
   } stateT;

endpackage

// File: rtl/compressed_stream_packer_byte_inserter.sv
// Combinational merge of a variable-length byte field into the accumulator
// at a byte offset. Bytes at and above the offset are replaced by the field.
module byte_inserter
   import packer_pkg::*;
(
   input  logic [8*BUF_BYTES-1:0]       bufIn,
   input  logic [6:0]                   offset,
   input  logic [8*MAX_GROUP_BYTES-1:0] field,
   input  logic [5:0]                   fieldLen,
   output logic [8*BUF_BYTES-1:0]       bufOut
);

   logic [8*BUF_BYTES-1:0] masked;
   logic [8*BUF_BYTES-1:0] keepMask;

   always_comb begin
      masked   = '0;
      keepMask = '0;
      for (int j = 0; j < MAX_GROUP_BYTES; j++) begin
         if (6'(j) < fieldLen) masked[8*j +: 8] = field[8*j +: 8];
      end
      for (int i = 0; i < BUF_BYTES; i++) begin
         if (7'(i) < offset) keepMask[8*i +: 8] = 8'hFF;
      end
      // Tail bytes beyond fieldLen stay zero so padding of the final word is free.
      bufOut = (bufIn & keepMask) | (masked << {offset, 3'b000});
   end

endmodule

// File: rtl/compressed_stream_packer.sv
// Serialises merged groups (2-byte tag header + payload) into 256-bit words.
// Optional PACKER_STATS_EN adds accepted group/byte counters.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a held outValid word keeps outData/outBytes/outLast stable until taken.
module compressed_stream_packer
   import packer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 2,
   parameter int LEN_WIDTH  = 8,
   parameter int NUM_UNITS  = 8,
   parameter int OUT_BYTES  = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            inValid,
   output logic                            inReady,
   input  logic [DATA_WIDTH*NUM_UNITS-1:0] inData,
   input  logic [TAG_WIDTH*NUM_UNITS-1:0]  inTag,
   input  logic [LEN_WIDTH-1:0]            inLen,
   input  logic                            flushIn,
   output logic                            outValid,
   input  logic                            outReady,
   output logic [8*OUT_BYTES-1:0]          outData,
   output logic [5:0]                      outBytes,
   output logic                            outLast,
   output logic [1:0]                      dbgState
`ifdef PACKER_STATS_EN
   ,
   output logic [31:0]                     groupCount,
   output logic [31:0]                     byteCount
`endif
);

   localparam int OUT_WIDTH   = 8*OUT_BYTES;
   localparam int MAX_PAYLOAD = DATA_WIDTH*NUM_UNITS/8;

   stateT                        state, stateNext;
   logic [8*BUF_BYTES-1:0]       buffer, bufShift, bufMerged, bufNext;
   logic [6:0]                   cnt, cntShift, cntNext;
   logic                         outFree, emit, emitLast, accept;
   logic [5:0]                   payLen, fieldLen;
   logic [8*MAX_GROUP_BYTES-1:0] field;

   assign dbgState = state;

   always_comb begin
      outFree  = !outValid || outReady;
      emit     = 1'b0;
      emitLast = 1'b0;
      case (state)
         RUN:     emit = outFree && (cnt >= 7'(OUT_BYTES));
         DRAIN: begin
            emit     = outFree;
            emitLast = (cnt <= 7'(OUT_BYTES));
         end
         default: ;
      endcase
   end

   // Emit happens before append, so the new group lands at the post-shift count.
   assign bufShift = emit ? (buffer >> OUT_WIDTH) : buffer;
   assign cntShift = emit ? (emitLast ? 7'd0 : cnt - 7'(OUT_BYTES)) : cnt;
   assign inReady  = (state == RUN) && (cntShift <= 7'(BUF_BYTES - MAX_GROUP_BYTES));
   assign accept   = inValid && inReady;

   assign payLen   = (inLen > LEN_WIDTH'(MAX_PAYLOAD)) ? 6'(MAX_PAYLOAD) : inLen[5:0];
   assign fieldLen = 6'(HDR_BYTES) + payLen;
   assign field    = {inData, inTag};

   byte_inserter uInserter (
      .bufIn    (bufShift),
      .offset   (cntShift),
      .field    (field),
      .fieldLen (fieldLen),
      .bufOut   (bufMerged)
   );

   assign bufNext = accept ? bufMerged : bufShift;
   assign cntNext = cntShift + (accept ? {1'b0, fieldLen} : 7'd0);

   always_comb begin
      stateNext = state;
      case (state)
         RUN:     if (flushIn) stateNext = DRAIN;
         DRAIN:   if (emit && emitLast) stateNext = LAST;
         LAST:    if (outValid && outReady) stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= RUN;
         buffer <= '0;
         cnt    <= 7'd0;
      end else begin
         state  <= stateNext;
         buffer <= bufNext;
         cnt    <= cntNext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outValid <= 1'b0;
         outData  <= '0;
         outBytes <= 6'd0;
         outLast  <= 1'b0;
      end else if (emit) begin
         outValid <= 1'b1;
         outData  <= buffer[OUT_WIDTH-1:0];
         outBytes <= emitLast ? cnt[5:0] : 6'(OUT_BYTES);
         outLast  <= emitLast;
      end else if (outReady) begin
         outValid <= 1'b0;
      end
   end

`ifdef PACKER_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         groupCount <= 32'd0;
         byteCount  <= 32'd0;
      end else if (accept) begin
         groupCount <= groupCount + 32'd1;
         byteCount  <= byteCount + 32'(fieldLen);
      end
   end
`endif

endmodule

// File: tb/tb_compressed_stream_packer.sv
// Self-checking bench for compressed_stream_packer: directed cases plus a
// randomized phase scored against a byte-queue model of the output stream.
module tb_compressed_stream_packer;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         inValid = 1'b0;
   logic         inReady;
   logic [255:0] inData = '0;
   logic [15:0]  inTag = '0;
   logic [7:0]   inLen = '0;
   logic         flushIn = 1'b0;
   logic         outValid;
   logic         outReady = 1'b0;
   logic [255:0] outData;
   logic [5:0]   outBytes;
   logic         outLast;
   logic [1:0]   dbgState;
`ifdef PACKER_STATS_EN
   logic [31:0]  groupCount;
   logic [31:0]  byteCount;
`endif

   int           nAsserts = 0;
   int           nFails = 0;
   logic [7:0]   exp_q[$];
   bit           closing = 1'b0;
   bit           lastAccepted = 1'b0;
   int           wordsSeen = 0;
   logic [255:0] lastData = '0;
   int           lastBytes = 0;
   bit           lastLast = 1'b0;
   bit           holdValid = 1'b0;
   logic [255:0] holdData = '0;
   logic [5:0]   holdBytes = '0;
   logic         holdLast = 1'b0;
   logic [31:0]  groupsAcc = '0;
   logic [31:0]  bytesAcc = '0;

   compressed_stream_packer dut (
      .clk      (clk),
      .reset    (reset),
      .inValid  (inValid),
      .inReady  (inReady),
      .inData   (inData),
      .inTag    (inTag),
      .inLen    (inLen),
      .flushIn  (flushIn),
      .outValid (outValid),
      .outReady (outReady),
      .outData  (outData),
      .outBytes (outBytes),
      .outLast  (outLast),
      .dbgState (dbgState)
`ifdef PACKER_STATS_EN
      ,
      .groupCount (groupCount),
      .byteCount  (byteCount)
`endif
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, nFails=%0d", nFails);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] randData();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   // One clock: sample handshakes at negedge, score, then return #1 after posedge.
   task automatic step();
      int n;
      int take;
      int plen;
      bit flushSeen;
      logic [255:0] w;
      @(negedge clk);
      flushSeen = flushIn && !closing;
      if (closing) check("inReady_closed", inReady, 1'b0);
      if (holdValid) begin
         check("hold_valid", outValid, 1'b1);
         check("hold_data", outData, holdData);
         check("hold_bytes", outBytes, holdBytes);
         check("hold_last", outLast, holdLast);
      end
      holdValid = outValid && !outReady;
      holdData  = outData;
      holdBytes = outBytes;
      holdLast  = outLast;
      lastAccepted = 1'b0;
      if (outValid && outReady) begin
         n = exp_q.size();
         if (n == 0 && !closing) begin
            check("spurious_word", outValid, 1'b0);
         end else begin
            take = (n >= 32) ? 32 : n;
            w = '0;
            for (int i = 0; i < take; i++) w[8*i +: 8] = exp_q.pop_front();
            check("out_data", outData, w);
            check("out_bytes", outBytes, take);
            if (closing && n < 32) begin
               check("out_last", outLast, 1'b1);
               closing = 1'b0;
            end else if (closing && n == 32) begin
               // Exactly one word left: either it closes the stream or an empty word follows.
               if (outLast) closing = 1'b0;
            end else begin
               check("out_last", outLast, 1'b0);
            end
         end
         wordsSeen++;
         lastData  = outData;
         lastBytes = outBytes;
         lastLast  = outLast;
      end
      if (inValid && inReady) begin
         plen = (inLen > 8'd32) ? 32 : int'(inLen);
         exp_q.push_back(inTag[7:0]);
         exp_q.push_back(inTag[15:8]);
         for (int i = 0; i < plen; i++) exp_q.push_back(inData[8*i +: 8]);
         groupsAcc = groupsAcc + 32'd1;
         bytesAcc  = bytesAcc + 32'(plen + 2);
         lastAccepted = 1'b1;
      end
      if (flushSeen) closing = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Driver tasks
   task automatic sendGroup(input logic [15:0] tag, input logic [7:0] len, input logic [255:0] data);
      int guard = 0;
      inValid = 1'b1;
      inTag   = tag;
      inLen   = len;
      inData  = data;
      do begin
         step();
         guard++;
      end while (!lastAccepted && guard < 100);
      check("send_accepted", lastAccepted, 1'b1);
      inValid = 1'b0;
   endtask

   task automatic drainAll();
      int guard = 0;
      inValid  = 1'b0;
      outReady = 1'b1;
      while (closing && guard < 200) begin
         step();
         guard++;
      end
      flushIn = 1'b1;
      step();
      flushIn = 1'b0;
      while (closing && guard < 400) begin
         step();
         guard++;
      end
      check("drain_done", closing, 1'b0);
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_outValid", outValid, 1'b0);
   endtask

   initial begin
      int base;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_outValid", outValid, 1'b0);
      check("rst_outData", outData, 256'h0);
      check("rst_outBytes", outBytes, 6'd0);
      check("rst_outLast", outLast, 1'b0);
      reset = 1'b0;
      #1;
      check("rst_inReady", inReady, 1'b1);

      // Single small group then flush
      outReady = 1'b1;
      base = wordsSeen;
      sendGroup(16'hA5C3, 8'd8, {randData() >> 64, 64'h0807060504030201});
      drainAll();
      check("single_words", wordsSeen - base, 1);
      check("single_data", lastData, 256'h0807060504030201A5C3);
      check("single_bytes", lastBytes, 10);
      check("single_last", lastLast, 1'b1);

      // Three maximum groups back-to-back
      base = wordsSeen;
      inValid = 1'b1; inTag = 16'($urandom); inLen = 8'd32; inData = randData();
      step();
      check("max_g0_acc", lastAccepted, 1'b1);
      check("max_latency_not_yet", outValid, 1'b0);
      inTag = 16'($urandom); inData = randData();
      step();
      check("max_g1_acc", lastAccepted, 1'b1);
      check("max_first_word", outValid, 1'b1);
      inTag = 16'($urandom); inData = randData();
      step();
      check("max_g2_acc", lastAccepted, 1'b1);
      inValid = 1'b0;
      drainAll();
      check("max_words", wordsSeen - base, 4);
      check("max_last_bytes", lastBytes, 6);

      // inReady boundary at 30/31 buffered bytes
      sendGroup(16'($urandom), 8'd28, randData());
      check("cnt30_inReady", inReady, 1'b1);
      drainAll();
      check("cnt30_last_bytes", lastBytes, 30);
      sendGroup(16'($urandom), 8'd29, randData());
      check("cnt31_inReady", inReady, 1'b0);
      drainAll();
      check("cnt31_last_bytes", lastBytes, 31);

      // Backpressure: held word plus 34 buffered bytes stalls input until outReady
      outReady = 1'b0;
      sendGroup(16'($urandom), 8'd30, randData());
      sendGroup(16'($urandom), 8'd32, randData());
      inValid = 1'b1; inTag = 16'($urandom); inLen = 8'd32; inData = randData();
      #1;
      check("bp_inReady_low0", inReady, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_no_accept", lastAccepted, 1'b0);
         check("bp_inReady_low", inReady, 1'b0);
      end
      outReady = 1'b1;
      #1;
      check("bp_inReady_release", inReady, 1'b1);
      step();
      check("bp_accept_on_release", lastAccepted, 1'b1);
      inValid = 1'b0;
      drainAll();
      check("bp_last_bytes", lastBytes, 4);

      // Flush with empty buffer
      base = wordsSeen;
      drainAll();
      check("empty_words", wordsSeen - base, 1);
      check("empty_bytes", lastBytes, 0);
      check("empty_last", lastLast, 1'b1);
      check("empty_back_to_run", inReady, 1'b1);

      // Oversized length saturates to 32 payload bytes
      base = wordsSeen;
      sendGroup(16'($urandom), 8'd40, randData());
      drainAll();
      check("sat_words", wordsSeen - base, 2);
      check("sat_last_bytes", lastBytes, 2);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         inValid  = ($urandom_range(0, 3) != 0);
         inTag    = 16'($urandom);
         inLen    = 8'($urandom_range(0, 40));
         inData   = randData();
         outReady = ($urandom_range(0, 9) < 7);
         flushIn  = ($urandom_range(0, 29) == 0);
         step();
      end
      flushIn = 1'b0;
      drainAll();
`ifdef PACKER_STATS_EN
      check("stats_groups", groupCount, groupsAcc);
      check("stats_bytes", byteCount, bytesAcc);
`endif

      // Reset in the middle of a drain with a held word
      outReady = 1'b0;
      sendGroup(16'($urandom), 8'd32, randData());
      sendGroup(16'($urandom), 8'd32, randData());
      flushIn = 1'b1;
      step();
      flushIn = 1'b0;
      step();
      check("pre_reset_outValid", outValid, 1'b1);
      reset = 1'b1;
      #1;
      check("midreset_outValid", outValid, 1'b0);
      check("midreset_outData", outData, 256'h0);
      check("midreset_outBytes", outBytes, 6'd0);
      check("midreset_outLast", outLast, 1'b0);
`ifdef PACKER_STATS_EN
      check("midreset_groupCount", groupCount, 32'd0);
      check("midreset_byteCount", byteCount, 32'd0);
`endif
      exp_q.delete();
      closing   = 1'b0;
      holdValid = 1'b0;
      groupsAcc = '0;
      bytesAcc  = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("postreset_inReady", inReady, 1'b1);
      base = wordsSeen;
      drainAll();
      check("postreset_words", wordsSeen - base, 1);
      check("postreset_bytes", lastBytes, 0);
      check("postreset_last", lastLast, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
